issue_ctrl: RTL and testbench

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl_pkg.sv | 25 ++
 rtl/issue_scoreboard.sv | 55 +++++
 rtl/issue_ctrl.sv | 175 +++++++++++++++++
 tb/tb_issue_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// issue_ctrl_pkg -- shared definitions for the issue controller.
//   * issue_state_e : issue FSM state encoding (RUN / DRAIN / POST / IDLE)
//   * SB_W          : scoreboard width (one busy bit per architectural register)
//   * REG_AW        : register-index width
// `WIDTH_UOP normally comes from define.vh; a fallback keeps this slice
// self-contained when that header is not part of the build.
// -----------------------------------------------------------------------------
`ifndef WIDTH_UOP
`define WIDTH_UOP 8
`endif

package issue_ctrl_pkg;

  localparam int SB_W   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_POST  = 2'd2,
    ST_IDLE  = 2'd3
  } issue_state_e;

endpackage

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard -- 32-entry busy scoreboard for long-latency results.
// Ports:
//   clk, aresetn            clock, asynchronous active-low reset
//   i_flush                 clears every busy bit at the next edge
//   i_set_en / i_set_rd     mark a destination busy (long op issued)
//   i_clr_en / i_clr_rd     release a destination (long op writeback)
//   i_q_rj/i_q_rk/i_q_rd    query operands of the issue candidate
//   o_q_hazard              any queried register busy
//   o_all_clear             no register busy
// r0 has no storage and always reads not-busy. Set wins over clear for the
// same register; queries see only registered state (no writeback bypass).
// -----------------------------------------------------------------------------
module issue_scoreboard
  import issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              aresetn,
  input  logic              i_flush,
  input  logic              i_set_en,
  input  logic [REG_AW-1:0] i_set_rd,
  input  logic              i_clr_en,
  input  logic [REG_AW-1:0] i_clr_rd,
  input  logic [REG_AW-1:0] i_q_rj,
  input  logic [REG_AW-1:0] i_q_rk,
  input  logic [REG_AW-1:0] i_q_rd,
  output logic              o_q_hazard,
  output logic              o_all_clear
);

  logic [SB_W-1:1] r_busy;
  logic [SB_W-1:0] w_busy;

  genvar gi;
  generate
    for (gi = 1; gi < SB_W; gi++) begin : g_busy
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          r_busy[gi] <= 1'b0;
        end else if (i_flush) begin
          r_busy[gi] <= 1'b0;
        end else if (i_set_en && (i_set_rd == REG_AW'(gi))) begin
          r_busy[gi] <= 1'b1;
        end else if (i_clr_en && (i_clr_rd == REG_AW'(gi))) begin
          r_busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign w_busy      = {r_busy, 1'b0};
  assign o_q_hazard  = w_busy[i_q_rj] | w_busy[i_q_rk] | w_busy[i_q_rd];
  assign o_all_clear = ~|r_busy;

endmodule

// File: rtl/issue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_ctrl -- in-order issue stage: DEPTH-entry uop FIFO, RAW/WAW scoreboard
// and a serialisation FSM for privileged / IDLE instructions.
// Ports:
//   clk, aresetn                      clock, asynchronous active-low reset
//   in_valid/in_ready + in_* fields   decoder-side handshake and uop fields
//   out_valid/out_ready + out_*       execute-side handshake, head uop fields
//   wb_long_valid/wb_long_rd          long-op writeback, releases scoreboard
//   pipe_empty, idle_wake, flush      downstream empty, wake request, flush
//   idle_stall                        high while parked in IDLE
// Build option: ISSUE_BYPASS_EN -- when defined, an input uop arriving at an
// empty FIFO in RUN may issue in the same cycle without being stored.
// -----------------------------------------------------------------------------
`ifndef WIDTH_UOP
`define WIDTH_UOP 8
`endif

module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int UOP_W = `WIDTH_UOP
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [UOP_W-1:0] in_uop,
  input  logic [31:0]      in_imm,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rj,
  input  logic [4:0]       in_rk,
  input  logic             in_serial,
  input  logic             in_idle,
  input  logic             in_long,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [UOP_W-1:0] out_uop,
  output logic [31:0]      out_imm,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rj,
  output logic [4:0]       out_rk,
  input  logic             wb_long_valid,
  input  logic [4:0]       wb_long_rd,
  input  logic             pipe_empty,
  input  logic             idle_wake,
  input  logic             flush,
  output logic             idle_stall
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ENT_W = UOP_W + 32 + 3 * REG_AW + 3;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  issue_state_e     r_state;
  issue_state_e     w_state_next;

  logic             w_empty, w_full, w_push, w_pop, w_issue, w_byp_sel;
  logic             w_hazard, w_all_clear;
  logic [ENT_W-1:0] w_in_ent;

  logic [UOP_W-1:0] w_head_uop;
  logic [31:0]      w_head_imm;
  logic [4:0]       w_head_rd, w_head_rj, w_head_rk;
  logic             w_head_serial, w_head_idle, w_head_long;

  logic             w_cand_valid, w_cand_serial, w_cand_long;

  // ---------------------------------------------------------------- FIFO
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  // Same index with differing wrap bit means the writer lapped the reader.
  assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                   (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);

  assign w_in_ent = {in_uop, in_imm, in_rd, in_rj, in_rk, in_serial, in_idle, in_long};
  assign {w_head_uop, w_head_imm, w_head_rd, w_head_rj, w_head_rk,
          w_head_serial, w_head_idle, w_head_long} = r_mem[r_rd_ptr[IDX_W-1:0]];

  assign in_ready = !w_full && !flush;

  // Candidate selection: the stored head, or the live input when bypassing.
`ifdef ISSUE_BYPASS_EN
  assign w_byp_sel = w_empty && (r_state == ST_RUN);
`else
  assign w_byp_sel = 1'b0;
`endif

  assign w_cand_valid  = w_byp_sel ? in_valid  : !w_empty;
  assign w_cand_serial = w_byp_sel ? in_serial : w_head_serial;
  assign w_cand_long   = w_byp_sel ? in_long   : w_head_long;
  assign out_uop       = w_byp_sel ? in_uop    : w_head_uop;
  assign out_imm       = w_byp_sel ? in_imm    : w_head_imm;
  assign out_rd        = w_byp_sel ? in_rd     : w_head_rd;
  assign out_rj        = w_byp_sel ? in_rj     : w_head_rj;
  assign out_rk        = w_byp_sel ? in_rk     : w_head_rk;

  assign w_issue = out_valid && out_ready;
  // A bypassed uop that is taken immediately never occupies a slot.
  assign w_push  = in_valid && in_ready && !(w_issue && w_byp_sel);
  assign w_pop   = w_issue && !w_byp_sel;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[IDX_W-1:0]] <= w_in_ent;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // ---------------------------------------------------------- scoreboard
  issue_scoreboard u_sb (
    .clk         (clk),
    .aresetn     (aresetn),
    .i_flush     (flush),
    .i_set_en    (w_issue && w_cand_long),
    .i_set_rd    (out_rd),
    .i_clr_en    (wb_long_valid),
    .i_clr_rd    (wb_long_rd),
    .i_q_rj      (out_rj),
    .i_q_rk      (out_rk),
    .i_q_rd      (out_rd),
    .o_q_hazard  (w_hazard),
    .o_all_clear (w_all_clear)
  );

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_RUN;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = ST_RUN;
    end else begin
      case (r_state)
        // A serial head is never issued from RUN; it waits in DRAIN.
        ST_RUN:   if (!w_empty && w_head_serial) w_state_next = ST_DRAIN;
        ST_DRAIN: if (w_issue) w_state_next = w_head_idle ? ST_IDLE : ST_POST;
        ST_POST:  if (pipe_empty) w_state_next = ST_RUN;
        ST_IDLE:  if (idle_wake) w_state_next = ST_RUN;
        default:  w_state_next = ST_RUN;
      endcase
    end
  end

  always_comb begin
    out_valid  = 1'b0;
    idle_stall = (r_state == ST_IDLE);
    if (!flush) begin
      case (r_state)
        ST_RUN:   out_valid = w_cand_valid && !w_cand_serial && !w_hazard;
        // Serial ops go only into a quiet machine: no in-flight ops, no pending long results.
        ST_DRAIN: out_valid = !w_empty && pipe_empty && w_all_clear;
        default:  out_valid = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_issue_ctrl -- self-checking bench for issue_ctrl: a stimulus table for
// FIFO fill/drain, hand-written sequences for hazard, serialisation, idle,
// flush and latency corners, then random traffic against a queue-based model.
// -----------------------------------------------------------------------------
module tb_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int UW    = 8;
`ifdef ISSUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          aresetn;
  logic          in_valid, in_ready;
  logic [UW-1:0] in_uop;
  logic [31:0]   in_imm;
  logic [4:0]    in_rd, in_rj, in_rk;
  logic          in_serial, in_idle, in_long;
  logic          out_valid, out_ready;
  logic [UW-1:0] out_uop;
  logic [31:0]   out_imm;
  logic [4:0]    out_rd, out_rj, out_rk;
  logic          wb_long_valid;
  logic [4:0]    wb_long_rd;
  logic          pipe_empty, idle_wake, flush, idle_stall;

  always #5 clk = ~clk;

  issue_ctrl #(.DEPTH(DEPTH), .UOP_W(UW)) dut (
    .clk(clk), .aresetn(aresetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop), .in_imm(in_imm),
    .in_rd(in_rd), .in_rj(in_rj), .in_rk(in_rk),
    .in_serial(in_serial), .in_idle(in_idle), .in_long(in_long),
    .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop), .out_imm(out_imm),
    .out_rd(out_rd), .out_rj(out_rj), .out_rk(out_rk),
    .wb_long_valid(wb_long_valid), .wb_long_rd(wb_long_rd),
    .pipe_empty(pipe_empty), .idle_wake(idle_wake), .flush(flush),
    .idle_stall(idle_stall)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ----------------------------------------------------- reference model
  typedef struct {
    logic [UW-1:0] uop;
    logic [31:0]   imm;
    logic [4:0]    rd, rj, rk;
    bit            serial, idle, lng;
  } uop_t;

  uop_t      mq[$];      // uops waiting, oldest first
  bit [31:0] mbusy;      // registers with a long result outstanding
  int        mmode;      // 0 normal issue, 1 draining, 2 post-serial wait, 3 idle

  // Values sampled from the DUT just before the edge, for hand-written checks.
  bit            s_in_ready, s_out_valid, s_idle_stall, s_issue;
  logic [UW-1:0] s_out_uop;

  function automatic uop_t cur_in();
    uop_t u;
    u.uop = in_uop; u.imm = in_imm; u.rd = in_rd; u.rj = in_rj; u.rk = in_rk;
    u.serial = in_serial; u.idle = in_idle; u.lng = in_long;
    return u;
  endfunction

  function automatic bit haz(uop_t u);
    return mbusy[u.rj] | mbusy[u.rk] | mbusy[u.rd];
  endfunction

  // One clock: entered at a falling edge with inputs already driven.
  task automatic tick();
    bit   e_ready, e_valid, byp, fired, h_serial, h_idle;
    uop_t e_u;
    #4;
    e_ready = (mq.size() < DEPTH) && !flush;
    e_valid = 1'b0;
    byp     = 1'b0;
    e_u     = cur_in();
    if (!flush) begin
      if (mmode == 0) begin
        if (mq.size() > 0) begin
          e_u = mq[0];
          e_valid = !e_u.serial && !haz(e_u);
        end else if (BYP && in_valid) begin
          byp = 1'b1;
          e_valid = !e_u.serial && !haz(e_u);
        end
      end else if (mmode == 1) begin
        if (mq.size() > 0 && pipe_empty && mbusy == 0) begin
          e_u = mq[0];
          e_valid = 1'b1;
        end
      end
    end
    check("in_ready", 32'(in_ready), 32'(e_ready));
    check("out_valid", 32'(out_valid), 32'(e_valid));
    check("idle_stall", 32'(idle_stall), 32'(mmode == 3));
    if (e_valid && out_valid) begin
      check("out_uop", 32'(out_uop), 32'(e_u.uop));
      check("out_imm", out_imm, e_u.imm);
      check("out_regs", 32'({out_rd, out_rj, out_rk}), 32'({e_u.rd, e_u.rj, e_u.rk}));
    end
    s_in_ready = in_ready; s_out_valid = out_valid; s_idle_stall = idle_stall;
    s_out_uop = out_uop;   s_issue = out_valid && out_ready;
    @(posedge clk);
    fired = e_valid && out_ready;
    if (flush) begin
      mq.delete();
      mbusy = '0;
      mmode = 0;
    end else begin
      h_serial = (mq.size() > 0) && mq[0].serial;
      h_idle   = (mq.size() > 0) && mq[0].idle;
      if (fired && !byp) void'(mq.pop_front());
      if (wb_long_valid) mbusy[wb_long_rd] = 1'b0;
      if (fired && e_u.lng && e_u.rd != 5'd0) mbusy[e_u.rd] = 1'b1;
      case (mmode)
        0: if (h_serial) mmode = 1;
        1: if (fired) mmode = h_idle ? 3 : 2;
        2: if (pipe_empty) mmode = 0;
        default: if (idle_wake) mmode = 0;
      endcase
      if (in_valid && e_ready && !(fired && byp)) mq.push_back(cur_in());
    end
    @(negedge clk);
  endtask

  task automatic quiet_inputs();
    in_valid = 0; in_uop = '0; in_imm = '0; in_rd = 0; in_rj = 0; in_rk = 0;
    in_serial = 0; in_idle = 0; in_long = 0; out_ready = 0;
    wb_long_valid = 0; wb_long_rd = 0; pipe_empty = 1; idle_wake = 0; flush = 0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    aresetn = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_idle_stall", 32'(idle_stall), 32'(0));
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    mq.delete();
    mbusy = '0;
    mmode = 0;
  endtask

  task automatic drive(input logic [UW-1:0] u, input logic [4:0] rd, input logic [4:0] rj,
                       input logic [4:0] rk, input bit ser, input bit idl, input bit lng);
    in_valid = 1; in_uop = u; in_imm = {24'hABCDEF, u}; in_rd = rd; in_rj = rj; in_rk = rk;
    in_serial = ser; in_idle = idl; in_long = lng;
  endtask

  task automatic wait_issue(input string name, input logic [UW-1:0] u, input int max_cyc);
    bit got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      tick();
      got = s_issue && (s_out_uop == u);
    end
    check(name, 32'(got), 32'(1));
  endtask

  // --------------------------------------------------------- vector table
  typedef struct {
    bit            iv;
    logic [UW-1:0] uop;
    bit            ordy;
    bit            e_rdy;
    bit            e_ov;
    logic [UW-1:0] e_uop;
  } vec_t;

  vec_t tbl[11];

  initial begin : main
    bit got;
    int r;

    // Fill to full with out_ready low, then drain in order.
    tbl[0]  = '{1, 8'h01, 0, 1, BYP, 8'h01};
    tbl[1]  = '{1, 8'h02, 0, 1, 1, 8'h01};
    tbl[2]  = '{1, 8'h03, 0, 1, 1, 8'h01};
    tbl[3]  = '{1, 8'h04, 0, 1, 1, 8'h01};
    tbl[4]  = '{1, 8'h05, 0, 0, 1, 8'h01};
    tbl[5]  = '{1, 8'h05, 1, 0, 1, 8'h01};
    tbl[6]  = '{1, 8'h05, 1, 1, 1, 8'h02};
    tbl[7]  = '{0, 8'h00, 1, 1, 1, 8'h03};
    tbl[8]  = '{0, 8'h00, 1, 1, 1, 8'h04};
    tbl[9]  = '{0, 8'h00, 1, 1, 1, 8'h05};
    tbl[10] = '{0, 8'h00, 1, 1, 0, 8'h00};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      in_valid = tbl[i].iv; in_uop = tbl[i].uop; in_imm = 32'(tbl[i].uop); out_ready = tbl[i].ordy;
      tick();
      check($sformatf("tbl%0d_in_ready", i), 32'(s_in_ready), 32'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_out_valid", i), 32'(s_out_valid), 32'(tbl[i].e_ov));
      if (tbl[i].e_ov)
        check($sformatf("tbl%0d_out_uop", i), 32'(s_out_uop), 32'(tbl[i].e_uop));
    end

    // RAW on a long op: held until writeback, issues exactly one cycle after.
    do_reset();
    out_ready = 1;
    drive(8'h20, 5, 0, 0, 0, 0, 1); tick();
    drive(8'h21, 6, 5, 0, 0, 0, 0); tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("raw_hold", 32'(s_out_valid), 32'(0));
    end
    wb_long_valid = 1; wb_long_rd = 5; tick();
    check("raw_no_wb_bypass", 32'(s_out_valid), 32'(0));
    wb_long_valid = 0; tick();
    check("raw_release_issue", 32'(s_issue && s_out_uop == 8'h21), 32'(1));

    // Serial op waits for an empty pipe, then the follower waits again.
    do_reset();
    out_ready = 1; pipe_empty = 0;
    drive(8'h30, 1, 2, 3, 1, 0, 0); tick();
    check("csr_run_no_issue", 32'(s_out_valid), 32'(0));
    drive(8'h31, 4, 0, 0, 0, 0, 0); tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("csr_drain_hold", 32'(s_out_valid), 32'(0));
    end
    pipe_empty = 1; tick();
    check("csr_issue", 32'(s_issue && s_out_uop == 8'h30), 32'(1));
    pipe_empty = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_hold", 32'(s_out_valid), 32'(0));
    end
    pipe_empty = 1; tick();
    check("post_exit_cycle", 32'(s_out_valid), 32'(0));
    tick();
    check("post_follower_issue", 32'(s_issue && s_out_uop == 8'h31), 32'(1));

    // IDLE: stalls until wake, follower issues the cycle after wake.
    do_reset();
    out_ready = 1;
    drive(8'h40, 0, 0, 0, 1, 1, 0); tick();
    drive(8'h41, 2, 0, 0, 0, 0, 0); tick();
    in_valid = 0;
    wait_issue("idle_op_issue", 8'h40, 6);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_hold", 32'({s_idle_stall, s_out_valid}), 32'(2'b10));
    end
    idle_wake = 1; tick();
    check("idle_wake_cycle", 32'(s_out_valid), 32'(0));
    idle_wake = 0; tick();
    check("idle_stall_clear", 32'(s_idle_stall), 32'(0));
    check("idle_follower_issue", 32'(s_issue && s_out_uop == 8'h41), 32'(1));

    // Reset while parked in IDLE discards the queue.
    do_reset();
    out_ready = 1;
    drive(8'h50, 0, 0, 0, 1, 1, 0); tick();
    drive(8'h51, 1, 0, 0, 0, 0, 0); tick();
    drive(8'h52, 2, 0, 0, 0, 0, 0); tick();
    in_valid = 0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      tick();
      got = s_idle_stall;
    end
    check("reach_idle", 32'(got), 32'(1));
    drive(8'h53, 3, 0, 0, 0, 0, 0); tick();
    do_reset();
    out_ready = 1; idle_wake = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_discard", 32'({s_out_valid, s_in_ready}), 32'(2'b01));
    end
    idle_wake = 0;

    // Flush with queued uops, busy r7, concurrent writeback and push.
    do_reset();
    out_ready = 1;
    drive(8'h60, 7, 0, 0, 0, 0, 1); tick();
    in_valid = 0; tick();
    out_ready = 0;
    drive(8'h61, 1, 0, 0, 0, 0, 0); tick();
    drive(8'h62, 2, 0, 0, 0, 0, 0); tick();
    drive(8'h63, 3, 0, 0, 0, 0, 0); tick();
    drive(8'h64, 4, 0, 0, 0, 0, 0);
    flush = 1; wb_long_valid = 1; wb_long_rd = 7; out_ready = 1; tick();
    check("flush_in_ready", 32'(s_in_ready), 32'(0));
    check("flush_out_valid", 32'(s_out_valid), 32'(0));
    flush = 0; wb_long_valid = 0; in_valid = 0; tick();
    check("flush_empty", 32'(s_out_valid), 32'(0));
    drive(8'h65, 8, 7, 0, 0, 0, 0); tick();
    in_valid = 0;
    if (!(s_issue && s_out_uop == 8'h65)) wait_issue("flush_sb_clear", 8'h65, 3);
    else check("flush_sb_clear", 32'(1), 32'(BYP));

    // Enqueue-to-issue latency.
    do_reset();
    out_ready = 1;
    drive(8'h70, 1, 2, 3, 0, 0, 0); tick();
    check("lat_same_cycle", 32'(s_out_valid), 32'(BYP));
    in_valid = 0; tick();
    check("lat_next_cycle", 32'(s_out_valid), 32'(!BYP));

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 99));
      in_valid      = ($urandom_range(0, 9) < 6);
      in_uop        = 8'($urandom);
      in_imm        = $urandom;
      in_rd         = 5'($urandom_range(0, 7));
      in_rj         = 5'($urandom_range(0, 7));
      in_rk         = 5'($urandom_range(0, 7));
      in_serial     = (r < 8);
      in_idle       = (r < 3);
      in_long       = (r >= 75);
      out_ready     = ($urandom_range(0, 9) < 7);
      pipe_empty    = ($urandom_range(0, 1) == 1);
      idle_wake     = ($urandom_range(0, 9) == 0);
      wb_long_valid = ($urandom_range(0, 3) == 0);
      wb_long_rd    = 5'($urandom_range(0, 7));
      flush         = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
